bin_to_sign_codes: RTL and testbench

- Sequential binary-to-BCD converter (shift-and-add-3, one bit per clock).
- Sits directly upstream of the eight-digit seven-segment scan driver and feeds its en and sign7..sign0 inputs.
- Outputs are held registers that update in a single cycle on completion, so the driver never shows a partial conversion.
- Out-of-range values produce an error pattern instead of wrapped digits.

---
 rtl/bin_to_sign_codes_pkg.sv | 27 ++
 rtl/bin_to_sign_codes_bcd_adj3.sv | 10 +
 rtl/bin_to_sign_codes.sv | 128 ++++++++++++
 tb/tb_bin_to_sign_codes.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/bin_to_sign_codes_pkg.sv
// Shared constants for producers feeding the eight-digit seven-segment scan driver.
// Holds the digit codes, the display range limit and the converter state encoding.
package bin_to_sign_codes_pkg;

    localparam logic [3:0] CODE_0          = 4'h0;
    localparam logic [3:0] CODE_1          = 4'h1;
    localparam logic [3:0] CODE_2          = 4'h2;
    localparam logic [3:0] CODE_3          = 4'h3;
    localparam logic [3:0] CODE_4          = 4'h4;
    localparam logic [3:0] CODE_5          = 4'h5;
    localparam logic [3:0] CODE_6          = 4'h6;
    localparam logic [3:0] CODE_7          = 4'h7;
    localparam logic [3:0] CODE_8          = 4'h8;
    localparam logic [3:0] CODE_9          = 4'h9;
    localparam logic [3:0] CODE_ERR        = 4'hE;
    // Decodes to a position-dependent glyph downstream; never produced by the converter.
    localparam logic [3:0] CODE_UNDERSCORE = 4'hA;

    localparam int unsigned MAX_VALUE = 32'd99_999_999;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CONV = 2'd1,
        ST_LOAD = 2'd2
    } state_t;

endpackage

// File: rtl/bin_to_sign_codes_bcd_adj3.sv
// Single BCD digit corrector for shift-and-add-3: digits of 5 or more get +3
// so the following left shift carries correctly into the next digit.
module bcd_adj3 (
    input  logic [3:0] digit,
    output logic [3:0] adjusted
);

    assign adjusted = (digit >= 4'd5) ? digit + 4'd3 : digit;

endmodule

// File: rtl/bin_to_sign_codes.sv
// Sequential binary-to-BCD converter producing held digit codes for the scan driver.
// One bit is converted per clock; outputs change only in the single LOAD cycle.
module bin_to_sign_codes #(
    parameter int          WIDTH     = 27,
    parameter int unsigned MAX_VALUE = bin_to_sign_codes_pkg::MAX_VALUE
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] value_in,
    output logic             busy,
    output logic             done,
    output logic             overflow,
    output logic             en,
    output logic [3:0]       sign7,
    output logic [3:0]       sign6,
    output logic [3:0]       sign5,
    output logic [3:0]       sign4,
    output logic [3:0]       sign3,
    output logic [3:0]       sign2,
    output logic [3:0]       sign1,
    output logic [3:0]       sign0
);

    import bin_to_sign_codes_pkg::*;

    // state   | meaning
    // --------+-------------------------------------------------------------
    // ST_IDLE | waiting for start; outputs hold the last completed result
    // ST_CONV | one add-3/shift step per clock, WIDTH steps in total
    // ST_LOAD | publish digits (or the error pattern), pulse done

    localparam int             CW      = $clog2(WIDTH + 1);
    localparam logic [WIDTH-1:0] MAX_CMP = WIDTH'(MAX_VALUE);
    localparam logic [CW-1:0]  LAST    = CW'(WIDTH - 1);

    state_t           state, state_next;
    logic             accept, shift, load;
    logic [WIDTH-1:0] bin_q;
    logic [31:0]      bcd_q;
    logic [31:0]      bcd_adj;
    logic [CW-1:0]    count;
    logic             ovf_pending;
    logic [31:0]      digits;

    for (genvar g = 0; g < 8; g++) begin : g_adj
        bcd_adj3 u_adj (
            .digit    (bcd_q[4*g +: 4]),
            .adjusted (bcd_adj[4*g +: 4])
        );
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        shift      = 1'b0;
        load       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    accept     = 1'b1;
                    state_next = ST_CONV;
                end
            end
            ST_CONV: begin
                shift = 1'b1;
                if (count == LAST) state_next = ST_LOAD;
            end
            ST_LOAD: begin
                load       = 1'b1;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= ST_IDLE;
        else      state <= state_next;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bin_q       <= '0;
            bcd_q       <= '0;
            count       <= '0;
            ovf_pending <= 1'b0;
        end else if (accept) begin
            bin_q       <= value_in;
            bcd_q       <= '0;
            count       <= '0;
            ovf_pending <= (value_in > MAX_CMP);
        end else if (shift) begin
            bcd_q       <= {bcd_adj[30:0], bin_q[WIDTH-1]};
            bin_q       <= {bin_q[WIDTH-2:0], 1'b0};
            count       <= count + CW'(1);
            // A bit leaving the top digit can only happen past MAX_VALUE; fold it in anyway.
            ovf_pending <= ovf_pending | bcd_adj[31];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            done     <= 1'b0;
            overflow <= 1'b0;
            en       <= 1'b0;
            digits   <= '0;
        end else begin
            done <= load;
            if (load) begin
                overflow <= ovf_pending;
                en       <= 1'b1;
                digits   <= ovf_pending ? {24'h0, CODE_ERR, CODE_ERR} : bcd_q;
            end
        end
    end

    assign busy  = (state != ST_IDLE);
    assign sign7 = digits[31:28];
    assign sign6 = digits[27:24];
    assign sign5 = digits[23:20];
    assign sign4 = digits[19:16];
    assign sign3 = digits[15:12];
    assign sign2 = digits[11:8];
    assign sign1 = digits[7:4];
    assign sign0 = digits[3:0];

endmodule

// File: tb/tb_bin_to_sign_codes.sv
// Scoreboard bench for bin_to_sign_codes: the driver queues hand-computed digit
// patterns with their due cycle, the monitor checks them on every done pulse.
module tb_bin_to_sign_codes;

    localparam int WIDTH = 27;
    localparam int LAT   = 28;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             start = 1'b0;
    logic [WIDTH-1:0] value_in = '0;
    logic             busy, done, overflow, en;
    logic [3:0]       sign7, sign6, sign5, sign4, sign3, sign2, sign1, sign0;
    logic [31:0]      shown;

    typedef struct {
        logic [31:0] digits;
        logic        ovf;
        int          due;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   last_done = -1;
    int   prev_done = -1;

    bin_to_sign_codes #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .value_in (value_in),
        .busy     (busy),
        .done     (done),
        .overflow (overflow),
        .en       (en),
        .sign7    (sign7),
        .sign6    (sign6),
        .sign5    (sign5),
        .sign4    (sign4),
        .sign3    (sign3),
        .sign2    (sign2),
        .sign1    (sign1),
        .sign0    (sign0)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign shown = {sign7, sign6, sign5, sign4, sign3, sign2, sign1, sign0};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (done) begin
            prev_done = last_done;
            last_done = cyc;
            if (sb.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                chk("digits", shown, mon_e.digits);
                chk("overflow", {31'd0, overflow}, {31'd0, mon_e.ovf});
                chk("en", {31'd0, en}, 32'd1);
                chk("busy_at_done", {31'd0, busy}, 32'd0);
                chk("latency_cycle", cyc, mon_e.due);
            end
        end
    end

    // Drives start for one edge from a non-edge time; returns 1 time unit after the edge.
    task automatic run_conv(input logic [WIDTH-1:0] v, input logic [31:0] exp_digits,
                            input logic exp_ovf, input bit expect_done);
        exp_t e;
        start    = 1'b1;
        value_in = v;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("busy_after_accept", {31'd0, busy}, 32'd1);
        if (expect_done) begin
            e.digits = exp_digits;
            e.ovf    = exp_ovf;
            e.due    = cyc + LAT;
            sb.push_back(e);
        end
    endtask

    task automatic wait_done(input string name);
        bit seen = 1'b0;
        for (int i = 0; i < LAT + 10 && !seen; i++) begin
            @(negedge clk);
            seen = done;
        end
        chk(name, {31'd0, seen}, 32'd1);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #12;
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_done", {31'd0, done}, 32'd0);
        chk("reset_en", {31'd0, en}, 32'd0);
        chk("reset_overflow", {31'd0, overflow}, 32'd0);
        chk("reset_signs", shown, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        idle(2);

        run_conv(27'd12345678, 32'h12345678, 1'b0, 1'b1);
        wait_done("done_12345678");
        idle(3);
        chk("hold_signs", shown, 32'h12345678);
        chk("hold_done_low", {31'd0, done}, 32'd0);

        run_conv(27'd0, 32'h00000000, 1'b0, 1'b1);
        wait_done("done_zero");
        idle(2);
        run_conv(27'd99999999, 32'h99999999, 1'b0, 1'b1);
        wait_done("done_max");
        idle(2);

        run_conv(27'd100000000, 32'h000000EE, 1'b1, 1'b1);
        wait_done("done_ovf");
        idle(2);
        run_conv(27'd42, 32'h00000042, 1'b0, 1'b1);
        wait_done("done_42");
        idle(2);

        // Starts during CONV (E5) and during LOAD (E28) must both be ignored.
        run_conv(27'd555, 32'h00000555, 1'b0, 1'b1);
        repeat (4) @(posedge clk);
        #1;
        start    = 1'b1;
        value_in = 27'd777;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (22) @(posedge clk);
        #1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("busy_after_load_start", {31'd0, busy}, 32'd0);
        idle(LAT + 5);
        chk("hold_555", shown, 32'h00000555);

        // Reset in mid-conversion aborts without a done pulse.
        run_conv(27'd87654321, 32'h0, 1'b0, 1'b0);
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("abort_signs", shown, 32'h0);
        chk("abort_en", {31'd0, en}, 32'd0);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_overflow", {31'd0, overflow}, 32'd0);
        chk("abort_done", {31'd0, done}, 32'd0);
        idle(2);
        rst = 1'b1;
        idle(LAT + 5);
        chk("abort_no_en", {31'd0, en}, 32'd0);

        run_conv(27'd1, 32'h00000001, 1'b0, 1'b1);
        wait_done("done_1");
        // Start on the first IDLE cycle after the done pulse is accepted.
        run_conv(27'd9, 32'h00000009, 1'b0, 1'b1);
        wait_done("done_9");
        #1;
        chk("b2b_spacing", last_done - prev_done, 32'd29);

        idle(5);
        chk("scoreboard_empty", sb.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
